// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor: measures the recurrence period of an lfsr state and flags lock-up or early repeats
module lfsr_period_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] status,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             lockup,
  output logic             repeat_err
);
  localparam int DEPTH = 1 << WIDTH;
  typedef enum logic [2:0] {IDLE, RUN, DONE, LOCK, RERR} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [DEPTH-1:0]   seen_q, seen_d;
  // state, counters, seed and visited-state bitmap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      ref_q    <= '0;
      seen_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ref_q    <= ref_d;
      seen_q   <= seen_d;
    end
  end
  // next state: mode low aborts everything; the seed check outranks the repeat check
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ref_d    = ref_q;
    seen_d   = seen_q;
    if (!mode) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      seen_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ref_d = status;
          if (status == '0) state_d = LOCK;
          else begin
            cnt_d          = '0;
            seen_d         = '0;
            seen_d[status] = 1'b1;
            state_d        = RUN;
          end
        end
        RUN: begin
          if (status == ref_q) begin
            period_d = cnt_q + CNT_W'(1);
            state_d  = DONE;
          end else if (status == '0) state_d = LOCK;
          else if (seen_q[status]) state_d = RERR;
          else begin
            cnt_d          = cnt_q + CNT_W'(1);
            seen_d[status] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign lockup     = state_q == LOCK;
  assign repeat_err = state_q == RERR;
  assign period     = done ? period_q : '0;
endmodule
